// File: rtl/i2c_slave.sv
// I2C target: 7-bit address match, byte write/read with ACK handling.
// Optional SCL/SDA majority glitch filter enabled by defining I2C_SLAVE_GLITCH_FILTER_EN.
module i2c_slave #(
  parameter logic [6:0] SLAVE_ADDR = 7'h50
) (
  input  logic       i2c_clk_in,
  input  logic       reset,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       busy,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    IDLE       = 4'd0,
    ADDRESS    = 4'd1,
    ADDR_ACK   = 4'd2,
    WRITE_DATA = 4'd3,
    WRITE_ACK  = 4'd4,
    READ_DATA  = 4'd5,
    READ_ACK   = 4'd6,
    WAIT_STOP  = 4'd7
  } state_t;

  logic [1:0] line_raw;
  logic [1:0] line_s;
  assign line_raw = {sda_in, scl_in};

  // Line 0 is SCL, line 1 is SDA.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_line
      logic meta_reg;
      logic sync_reg;
      always_ff @(posedge i2c_clk_in) begin
        if (reset) begin
          meta_reg <= 1'b1;
          sync_reg <= 1'b1;
        end else begin
          meta_reg <= line_raw[gi];
          sync_reg <= meta_reg;
        end
      end
`ifdef I2C_SLAVE_GLITCH_FILTER_EN
      logic [2:0] hist_reg;
      always_ff @(posedge i2c_clk_in) begin
        if (reset) hist_reg <= 3'b111;
        else       hist_reg <= {hist_reg[1:0], sync_reg};
      end
      assign line_s[gi] = (hist_reg[0] & hist_reg[1]) | (hist_reg[0] & hist_reg[2]) |
                          (hist_reg[1] & hist_reg[2]);
`else
      assign line_s[gi] = sync_reg;
`endif
    end
  endgenerate

  logic scl_s, sda_s;
  assign scl_s = line_s[0];
  assign sda_s = line_s[1];

  logic       scl_prev_reg, sda_prev_reg;
  state_t     state_reg, state_next;
  logic [2:0] bit_cnt_reg, bit_cnt_next;
  logic [7:0] shift_reg, shift_next;
  logic       sda_oe_reg, sda_oe_next;
  logic       busy_reg, busy_next;
  logic [7:0] rx_data_reg, rx_data_next;
  logic       rx_valid_reg, rx_valid_next;
  logic       tx_ready_reg, tx_ready_next;

  // SCL must be high on both samples so a data change at an SCL edge is not a condition.
  logic start_det, stop_det, scl_rise, scl_fall;
  assign start_det = scl_s & scl_prev_reg & sda_prev_reg & ~sda_s;
  assign stop_det  = scl_s & scl_prev_reg & ~sda_prev_reg & sda_s;
  assign scl_rise  = scl_s & ~scl_prev_reg;
  assign scl_fall  = ~scl_s & scl_prev_reg;

  always_comb begin
    state_next    = state_reg;
    bit_cnt_next  = bit_cnt_reg;
    shift_next    = shift_reg;
    sda_oe_next   = sda_oe_reg;
    busy_next     = busy_reg;
    rx_data_next  = rx_data_reg;
    rx_valid_next = 1'b0;
    tx_ready_next = 1'b0;
    if (stop_det) begin
      state_next   = IDLE;
      bit_cnt_next = 3'd0;
      sda_oe_next  = 1'b0;
      busy_next    = 1'b0;
    end else if (start_det) begin
      state_next   = ADDRESS;
      bit_cnt_next = 3'd7;
      sda_oe_next  = 1'b0;
      busy_next    = 1'b0;
    end else begin
      case (state_reg)
        ADDRESS: if (scl_rise) begin
          shift_next = {shift_reg[6:0], sda_s};
          if (bit_cnt_reg == 3'd0) begin
            if (shift_reg[6:0] == SLAVE_ADDR) begin
              state_next   = ADDR_ACK;
              busy_next    = 1'b1;
              bit_cnt_next = 3'd1;
            end else begin
              state_next  = WAIT_STOP;
              sda_oe_next = 1'b0;
            end
          end else begin
            bit_cnt_next = bit_cnt_reg - 3'd1;
          end
        end
        // Counter value 1 marks the first falling edge (start driving ACK); 0 marks the end of the ACK clock.
        ADDR_ACK: if (scl_fall) begin
          if (bit_cnt_reg == 3'd1) begin
            sda_oe_next  = 1'b1;
            bit_cnt_next = 3'd0;
          end else begin
            bit_cnt_next = 3'd7;
            if (shift_reg[0]) begin
              state_next    = READ_DATA;
              shift_next    = tx_data;
              tx_ready_next = 1'b1;
              sda_oe_next   = ~tx_data[7];
            end else begin
              state_next  = WRITE_DATA;
              sda_oe_next = 1'b0;
            end
          end
        end
        WRITE_DATA: if (scl_rise) begin
          shift_next = {shift_reg[6:0], sda_s};
          if (bit_cnt_reg == 3'd0) begin
            rx_data_next  = {shift_reg[6:0], sda_s};
            rx_valid_next = 1'b1;
            state_next    = WRITE_ACK;
            bit_cnt_next  = 3'd1;
          end else begin
            bit_cnt_next = bit_cnt_reg - 3'd1;
          end
        end
        WRITE_ACK: if (scl_fall) begin
          if (bit_cnt_reg == 3'd1) begin
            sda_oe_next  = 1'b1;
            bit_cnt_next = 3'd0;
          end else begin
            sda_oe_next  = 1'b0;
            state_next   = WRITE_DATA;
            bit_cnt_next = 3'd7;
          end
        end
        READ_DATA: if (scl_fall) begin
          if (bit_cnt_reg == 3'd0) begin
            sda_oe_next = 1'b0;
            state_next  = READ_ACK;
          end else begin
            shift_next   = {shift_reg[6:0], 1'b0};
            sda_oe_next  = ~shift_reg[6];
            bit_cnt_next = bit_cnt_reg - 3'd1;
          end
        end
        // A falling edge is only seen here after the master ACKed on the rising edge.
        READ_ACK: begin
          if (scl_rise && sda_s) begin
            state_next = WAIT_STOP;
          end else if (scl_fall) begin
            state_next    = READ_DATA;
            shift_next    = tx_data;
            tx_ready_next = 1'b1;
            sda_oe_next   = ~tx_data[7];
            bit_cnt_next  = 3'd7;
          end
        end
        IDLE, WAIT_STOP: sda_oe_next = 1'b0;
        default: begin
          state_next  = IDLE;
          sda_oe_next = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge i2c_clk_in) begin
    if (reset) begin
      scl_prev_reg <= 1'b1;
      sda_prev_reg <= 1'b1;
      state_reg    <= IDLE;
      bit_cnt_reg  <= 3'd0;
      shift_reg    <= 8'h00;
      sda_oe_reg   <= 1'b0;
      busy_reg     <= 1'b0;
      rx_data_reg  <= 8'h00;
      rx_valid_reg <= 1'b0;
      tx_ready_reg <= 1'b0;
    end else begin
      scl_prev_reg <= scl_s;
      sda_prev_reg <= sda_s;
      state_reg    <= state_next;
      bit_cnt_reg  <= bit_cnt_next;
      shift_reg    <= shift_next;
      sda_oe_reg   <= sda_oe_next;
      busy_reg     <= busy_next;
      rx_data_reg  <= rx_data_next;
      rx_valid_reg <= rx_valid_next;
      tx_ready_reg <= tx_ready_next;
    end
  end

  assign sda_oe   = sda_oe_reg;
  assign busy     = busy_reg;
  assign rx_data  = rx_data_reg;
  assign rx_valid = rx_valid_reg;
  assign tx_ready = tx_ready_reg;
  assign state    = state_reg;

endmodule
